md_seq: RTL

Sequencing controller for the shared multiply/divide unit in the P7 pipeline. It accepts MD-class operations from the E stage and gates them against the interrupt request from M. It runs the fixed-latency busy window, drives the D-stage stall, and pulses the HI/LO write enables at commit. The datapath computes products and quotients; this block only decides when an operation starts, how long it occupies the unit, and whether its result is written.

---
 rtl/md_seq.sv | 84 ++++++++
 1 files changed

// File: rtl/md_seq.sv
// Sequencing controller for the shared multiply/divide unit: issue gating,
// fixed-latency busy window, D-stage stall and HI/LO write-enable timing.
module md_seq #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       e_op,
   input  logic             e_b_zero,
   input  logic             int_req,
   input  logic             d_md_use,
   output logic             md_start,
   output logic [1:0]       md_kind,
   output logic             busy,
   output logic [CNT_W-1:0] cnt,
   output logic             commit_we,
   output logic             hi_we,
   output logic             lo_we,
   output logic             stall_d
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   state_t state;
   logic   zero_flag;
   logic   is_start;
   logic   is_div;
   logic   idle;
   logic   e_live;

   assign is_start = (e_op != 3'd0) && (e_op <= 3'd4);
   assign is_div   = (e_op == 3'd3) || (e_op == 3'd4);
   assign idle     = (state == IDLE);
   // A flushed E-stage op (int_req) must not touch the unit or HI/LO.
   assign e_live   = !reset && !int_req;

   assign md_start  = e_live && idle && is_start;
   assign hi_we     = e_live && idle && (e_op == 3'd5);
   assign lo_we     = e_live && idle && (e_op == 3'd6);
   assign busy      = (state == RUN);
   assign commit_we = !reset && busy && (cnt == ONE_CNT) && !zero_flag;
   assign stall_d   = !reset && d_md_use && (busy || (is_start && !int_req));

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         md_kind   <= 2'd0;
         zero_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (md_start) begin
                  state     <= RUN;
                  cnt       <= is_div ? DIV_CNT : MULT_CNT;
                  // ops 1..4 map onto kinds 0..3 (op 4 wraps 0 - 1 to 3)
                  md_kind   <= e_op[1:0] - 2'd1;
                  zero_flag <= is_div && e_b_zero;
               end
            end
            RUN: begin
               // Start-class ops arriving here are ignored; the op in flight always finishes.
               if (cnt == ONE_CNT) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - ONE_CNT;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
